// File: rtl/sdm_cic_decim.sv
// sdm_cic_decim: second-order CIC decimator for a 1-bit sigma-delta stream.
// Two wrapping integrators run at the input sample rate. A registered strobe
// fires once every R accepted samples. On the cycle after the strobe the
// two-stage comb, scaling and saturation produce one PCM word.
// The first two strobes after reset only prime the comb delays.
module sdm_cic_decim #(
  parameter int dac_bw   = 16,
  parameter int dec_log2 = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic                     din,
  output logic                     valid_out,
  output logic signed [dac_bw-1:0] dout
);

  // Internal CIC width: bit growth of 2*dec_log2 on top of the 2-bit sample.
  localparam int W     = 2 + 2*dec_log2;
  // Left shift that places full-scale CIC gain (R^2) at PCM full scale.
  localparam int SHIFT = dac_bw - 1 - 2*dec_log2;
  // Width of the scaled value before saturation (equals dac_bw + 1).
  localparam int YW    = W + SHIFT;

  localparam logic [dec_log2-1:0] PHASE_LAST = '1;
  localparam logic signed [YW-1:0] Y_MAX = YW'((64'sd1 <<< (dac_bw-1)) - 64'sd1);
  localparam logic signed [YW-1:0] Y_MIN = ~Y_MAX;

  if ((dec_log2 < 3) || (2*dec_log2 > dac_bw-1)) begin : g_param_check
    $error("sdm_cic_decim: need 3 <= dec_log2 and 2*dec_log2 <= dac_bw-1");
  end

  // Clamp the scaled comb output into the signed PCM range.
  function automatic logic signed [dac_bw-1:0] sat_fn(input logic signed [YW-1:0] v);
    logic signed [dac_bw-1:0] r;
    if (v > Y_MAX) begin
      r = Y_MAX[dac_bw-1:0];
    end else if (v < Y_MIN) begin
      r = Y_MIN[dac_bw-1:0];
    end else begin
      r = v[dac_bw-1:0];
    end
    return r;
  endfunction

  logic signed [W-1:0]      x_s;
  logic signed [W-1:0]      i1_next_s;
  logic signed [W-1:0]      i2_next_s;
  logic signed [W-1:0]      c1_s;
  logic signed [W-1:0]      c2_s;
  logic signed [YW-1:0]     y_wide_s;
  logic signed [dac_bw-1:0] y_sat_s;

  logic signed [W-1:0]      i1_r;
  logic signed [W-1:0]      i2_r;
  logic signed [W-1:0]      i2_d_r;
  logic signed [W-1:0]      c1_d_r;
  logic [dec_log2-1:0]      phase_r;
  logic                     strobe_r;
  logic [1:0]               warm_r;
  logic                     valid_out_r;
  logic signed [dac_bw-1:0] dout_r;

  assign valid_out = valid_out_r;
  assign dout      = dout_r;

  // Sample mapping, integrator next values, comb differences and scaling.
  always_comb begin
    x_s       = '0;
    i1_next_s = '0;
    i2_next_s = '0;
    c1_s      = '0;
    c2_s      = '0;
    y_wide_s  = '0;
    y_sat_s   = '0;
    if (din) begin
      x_s = {W{1'b1}};
    end else begin
      x_s = {{(W-1){1'b0}}, 1'b1};
    end
    i1_next_s = i1_r + x_s;
    i2_next_s = i2_r + i1_next_s;
    c1_s      = i2_r - i2_d_r;
    c2_s      = c1_s - c1_d_r;
    y_wide_s  = YW'(c2_s);
    y_wide_s  = y_wide_s <<< SHIFT;
    y_sat_s   = sat_fn(y_wide_s);
  end

  // Integrators: advance only on accepted samples, wrapping modulo 2^W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_r <= '0;
      i2_r <= '0;
    end else if (valid_in) begin
      i1_r <= i1_next_s;
      i2_r <= i2_next_s;
    end
  end

  // Phase counter and decimation strobe; strobe is high for one cycle after
  // the edge that accepts the last sample of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r  <= '0;
      strobe_r <= 1'b0;
    end else if (valid_in) begin
      if (phase_r == PHASE_LAST) begin
        phase_r  <= '0;
        strobe_r <= 1'b1;
      end else begin
        phase_r  <= phase_r + dec_log2'(1);
        strobe_r <= 1'b0;
      end
    end else begin
      strobe_r <= 1'b0;
    end
  end

  // Comb delays, warm-up suppression and the registered PCM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i2_d_r      <= '0;
      c1_d_r      <= '0;
      warm_r      <= 2'd0;
      valid_out_r <= 1'b0;
      dout_r      <= '0;
    end else if (strobe_r) begin
      i2_d_r <= i2_r;
      c1_d_r <= c1_s;
      if (warm_r != 2'd2) begin
        warm_r      <= warm_r + 2'd1;
        valid_out_r <= 1'b0;
      end else begin
        dout_r      <= y_sat_s;
        valid_out_r <= 1'b1;
      end
    end else begin
      valid_out_r <= 1'b0;
    end
  end

endmodule
